temporizador: RTL and testbench

Three-phase sequence timer for the red/green/blue drive path. A rising edge on `enter` starts one pass that asserts a one-hot phase flag for a programmable number of clock cycles per phase, in the order R, G, B. After the pass it returns to idle. It sits between the user-input logic, which supplies the start strobe and the per-phase cycle counts, and the LED/colour output stage, which consumes `flags`.

---
 rtl/temporizador_pkg.sv | 12 +
 rtl/temporizador_edge.sv | 13 +
 rtl/temporizador.sv | 60 ++++++
 tb/tb_temporizador.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/temporizador_pkg.sv
// temporizador_pkg: shared states, flag encodings and default width for the RGB phase timer.
package temporizador_pkg;
   localparam int W_DEF = 5;
   typedef enum logic [1:0] {IDLE, RED, GREEN, BLUE} state_t;
   localparam logic [2:0] FLAG_NONE = 3'b000;
   localparam logic [2:0] FLAG_R    = 3'b001;
   localparam logic [2:0] FLAG_G    = 3'b010;
   localparam logic [2:0] FLAG_B    = 3'b100;
   function automatic logic [2:0] flag_of(state_t s);
      return s == RED ? FLAG_R : s == GREEN ? FLAG_G : s == BLUE ? FLAG_B : FLAG_NONE;
   endfunction
endpackage

// File: rtl/temporizador_edge.sv
// temporizador_edge: rising-edge detector, reset clears the history so a high input counts as an edge.
module temporizador_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise
);
   logic r_d;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_d <= 1'b0;
      else     r_d <= i_sig;
   assign o_rise = i_sig & ~r_d;
endmodule

// File: rtl/temporizador.sv
// temporizador: one R->G->B pass per enter edge, each phase held for its latched cycle count.
module temporizador
   import temporizador_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enter,
   input  logic [W-1:0] ciclos_R,
   input  logic [W-1:0] ciclos_G,
   input  logic [W-1:0] ciclos_B,
   output logic [2:0]   flags
);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   state_t       r_state, w_next;
   logic [W-1:0] r_cnt, r_lat_r, r_lat_g, r_lat_b;
   logic [W-1:0] w_r, w_g, w_b, w_load;
   logic         w_start, w_idle, w_adv;
   temporizador_edge u_edge (
      .clk   (clk),
      .rst   (rst),
      .i_sig (enter),
      .o_rise(w_start)
   );
   // In IDLE the live inputs stand in for the latches so the first phase starts on the start edge.
   always_comb begin
      w_idle = r_state == IDLE;
      w_r    = w_idle ? ciclos_R : r_lat_r;
      w_g    = w_idle ? ciclos_G : r_lat_g;
      w_b    = w_idle ? ciclos_B : r_lat_b;
      w_adv  = w_idle ? w_start : r_cnt == '0;
      w_next = r_state;
      if (w_adv)
         w_next = (w_idle && w_r != '0) ? RED :
                  ((w_idle || r_state == RED) && w_g != '0) ? GREEN :
                  (r_state != BLUE && w_b != '0) ? BLUE : IDLE;
      w_load = w_next == RED ? w_r - ONE : w_next == GREEN ? w_g - ONE :
               w_next == BLUE ? w_b - ONE : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         flags   <= FLAG_NONE;
         r_cnt   <= '0;
         r_lat_r <= '0;
         r_lat_g <= '0;
         r_lat_b <= '0;
      end else begin
         r_state <= w_next;
         flags   <= flag_of(w_next);
         r_cnt   <= w_adv ? w_load : w_idle ? r_cnt : r_cnt - ONE;
         if (w_idle && w_start) begin
            r_lat_r <= ciclos_R;
            r_lat_g <= ciclos_G;
            r_lat_b <= ciclos_B;
         end
      end
   end
endmodule

// File: tb/tb_temporizador.sv
// tb_temporizador: directed scenarios plus random enter/count/reset traffic against a queue-based model.
module tb_temporizador;
   import temporizador_pkg::*;
   localparam int W = 5;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enter = 1'b0;
   logic [W-1:0] cr = '0, cg = '0, cb = '0;
   logic [2:0]   flags;
   int           checks = 0, errors = 0;
   logic [2:0]   exp_f = 3'b000;
   logic         pe = 1'b0;
   logic [2:0]   q[$];
   int           a, b, c, nz;

   temporizador #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .enter   (enter),
      .ciclos_R(cr),
      .ciclos_G(cg),
      .ciclos_B(cb),
      .flags   (flags)
   );

   always #5 clk = ~clk;

   // Model: a pass is just the flag sequence R x cr, G x cg, B x cb played out one per clock.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         pe = 1'b0;
         exp_f = 3'b000;
      end else begin
         if (exp_f == 3'b000 && enter && !pe) begin
            for (int i = 0; i < int'(cr); i++) q.push_back(3'b001);
            for (int i = 0; i < int'(cg); i++) q.push_back(3'b010);
            for (int i = 0; i < int'(cb); i++) q.push_back(3'b100);
         end
         pe = enter;
         exp_f = q.size() != 0 ? q.pop_front() : 3'b000;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (flags !== exp_f) begin
         errors++;
         $display("FAIL model t=%0t flags=%b expected=%b", $time, flags, exp_f);
      end
   end

   task automatic lit(input string n, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, got, want);
      end
   endtask

   task automatic pass(input int h, input int n, output int ra, output int rg, output int rb);
      ra = 0; rg = 0; rb = 0;
      enter = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ra += int'(flags == 3'b001);
         rg += int'(flags == 3'b010);
         rb += int'(flags == 3'b100);
         if (i == h - 1) enter = 1'b0;
      end
   endtask

   initial begin
      cr = 5; cg = 10; cb = 15;
      #12;
      lit("reset_flags", int'(flags), 0);
      @(negedge clk);
      rst = 1'b0;
      pass(10, 40, a, b, c);
      lit("held_R", a, 5); lit("held_G", b, 10); lit("held_B", c, 15);

      cr = 3; cg = 0; cb = 2;
      pass(1, 10, a, b, c);
      lit("skipG_R", a, 3); lit("skipG_G", b, 0); lit("skipG_B", c, 2);

      cr = 0; cg = 0; cb = 0;
      pass(1, 10, a, b, c);
      lit("zero_R", a, 0); lit("zero_G", b, 0); lit("zero_B", c, 0);

      cr = 5; cg = 10; cb = 15;
      a = 0; b = 0; c = 0;
      enter = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         a += int'(flags == 3'b001);
         b += int'(flags == 3'b010);
         c += int'(flags == 3'b100);
         if (i == 0) enter = 1'b0;
         if (i == 7) enter = 1'b1;
         if (i == 8) begin
            enter = 1'b0;
            cb = 1;
         end
      end
      lit("retrig_R", a, 5); lit("retrig_G", b, 10); lit("retrig_B", c, 15);

      cr = 31; cg = 31; cb = 31;
      pass(1, 100, a, b, c);
      lit("max_R", a, 31); lit("max_G", b, 31); lit("max_B", c, 31);

      cr = 5; cg = 10; cb = 15;
      enter = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         enter = 1'b0;
      end
      lit("pre_rst_G", int'(flags), 2);
      #2 rst = 1'b1;
      #1 lit("rst_async", int'(flags), 0);
      @(negedge clk);
      rst = 1'b0;
      nz = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         nz += int'(flags != 3'b000);
      end
      lit("idle_after_rst", nz, 0);
      pass(1, 35, a, b, c);
      lit("post_rst_R", a, 5); lit("post_rst_G", b, 10); lit("post_rst_B", c, 15);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         enter = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 15) == 0) begin
            cr = W'($urandom_range(0, 7));
            cg = W'($urandom_range(0, 7));
            cb = W'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
